vvm_seq: RTL and testbench

Sequencer that drives one `vvm` dot-product engine to compute a matrix-vector product of up to `M` rows against a shared vector. Accepts a command, loads the vector once, fetches rows one at a time from an external row memory, launches `vvm`, and returns one signed result per row over a valid/ready stream. Sits between the STMM command decoder and the `vvm` instance inside `exec_unit/stmm`.

---
 rtl/stmm_pkg.sv | 20 ++
 rtl/vvm_seq_rowbuf.sv | 35 +++
 rtl/vvm_seq.sv | 198 +++++++++++++++++++
 tb/tb_vvm_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stmm_pkg.sv
// Shared types and helpers for the STMM matrix-vector sequencer (vvm_seq).
// VVM_SEQ_PREFETCH_EN adds the launch-from-buffer state.
package stmm_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StRun   = 3'd2,
    StEmit  = 3'd3
`ifdef VVM_SEQ_PREFETCH_EN
    , StLaunch = 3'd4
`endif
  } seq_state_e;

  // Cycles one vvm run takes for a vector of l elements with window w.
  function automatic int unsigned calc_wl(input int unsigned l, input int unsigned w);
    return l / w;
  endfunction

endpackage

// File: rtl/vvm_seq_rowbuf.sv
// One-entry row buffer with full flag; holds a prefetched row until the sequencer launches it.
module vvm_seq_rowbuf #(
  parameter int unsigned L = 176,
  parameter int unsigned Q = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           pop,
  input  logic [L*Q-1:0] din,
  output logic [L*Q-1:0] dout,
  output logic           full
);

  logic [L*Q-1:0] data_q;
  logic           full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load) begin
        data_q <= din;
        full_q <= 1'b1;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/vvm_seq.sv
// Matrix-vector sequencer around one vvm engine: vector loaded once per command, one row per run.
// VVM_SEQ_PREFETCH_EN overlaps the next row fetch with the current run (vvm_seq_rowbuf).
module vvm_seq
  import stmm_pkg::*;
#(
  parameter int unsigned L  = 176,
  parameter int unsigned W  = 4,
  parameter int unsigned Q  = 8,
  parameter int unsigned DQ = 18,
  parameter int unsigned M  = 16,
  localparam int unsigned RW = $clog2(M + 1),
  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [RW-1:0]        cmd_rows,
  input  logic [L*Q-1:0]       vec_data,
  output logic                 row_req,
  output logic [IW-1:0]        row_idx,
  input  logic                 row_valid,
  input  logic [L*Q-1:0]       row_data,
  output logic [L*Q-1:0]       A_in,
  output logic [L*Q-1:0]       B_in,
  output logic                 A_ld,
  output logic                 B_ld,
  output logic                 start,
  input  logic                 vvm_rdy,
  input  logic signed [DQ-1:0] vvm_C,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [DQ-1:0] res_data,
  output logic [IW-1:0]        res_idx,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done
);

  if (W == 0 || (L % W) != 0) begin : g_bad_cfg
    $error("vvm_seq: L must be a non-zero multiple of W");
  end

  localparam logic [IW-1:0] IdxOne = IW'(1);
  localparam logic [RW-1:0] RowOne = RW'(1);

  seq_state_e           state_q;
  logic [RW-1:0]        rows_q;
  logic [IW-1:0]        idx_q;
  logic                 req_q;
  logic [IW-1:0]        req_idx_q;
  logic                 guard_q;
  logic                 res_valid_q;
  logic signed [DQ-1:0] res_data_q;
  logic [IW-1:0]        res_idx_q;
  logic                 res_last_q;
  logic                 done_q;

  logic accept, row_hit, fetch_go, launch, last_row;
  logic [L*Q-1:0] launch_row;

  assign accept   = (state_q == StIdle) && cmd_valid;
  assign row_hit  = req_q && row_valid;  // stray row_valid without a request is dropped
  assign fetch_go = (state_q == StFetch) && row_hit;
  assign last_row = (RW'(idx_q) + RowOne) == rows_q;

`ifdef VVM_SEQ_PREFETCH_EN
  logic buf_load, buf_full, has_next;

  assign launch   = (state_q == StLaunch);
  assign buf_load = row_hit && (state_q != StFetch);
  assign has_next = (RW'(idx_q) + RowOne) < rows_q;

  vvm_seq_rowbuf #(
    .L(L),
    .Q(Q)
  ) u_rowbuf (
    .clk (clk),
    .rst (rst),
    .load(buf_load),
    .pop (launch),
    .din (row_data),
    .dout(launch_row),
    .full(buf_full)
  );
`else
  assign launch     = 1'b0;
  assign launch_row = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rows_q      <= '0;
      idx_q       <= '0;
      req_q       <= 1'b0;
      req_idx_q   <= '0;
      guard_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (row_hit) req_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            rows_q <= cmd_rows;
            idx_q  <= '0;
            if (cmd_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= StFetch;
              req_q     <= 1'b1;
              req_idx_q <= '0;
            end
          end
        end
        StFetch: begin
          if (row_hit) begin
            state_q <= StRun;
            guard_q <= 1'b1;
`ifdef VVM_SEQ_PREFETCH_EN
            if (has_next) begin
              req_q     <= 1'b1;
              req_idx_q <= idx_q + IdxOne;
            end
`endif
          end
        end
`ifdef VVM_SEQ_PREFETCH_EN
        StLaunch: begin
          state_q <= StRun;
          guard_q <= 1'b1;
          if (has_next) begin
            req_q     <= 1'b1;
            req_idx_q <= idx_q + IdxOne;
          end
        end
`endif
        StRun: begin
          // vvm_rdy still shows the idle level in the cycle right after start
          guard_q <= 1'b0;
          if (!guard_q && vvm_rdy) begin
            res_valid_q <= 1'b1;
            res_data_q  <= vvm_C;
            res_idx_q   <= idx_q;
            res_last_q  <= last_row;
            state_q     <= StEmit;
          end
        end
        StEmit: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (res_last_q) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + IdxOne;
`ifdef VVM_SEQ_PREFETCH_EN
              // Row may land in the buffer this very cycle; a pending request stays pending.
              state_q <= (buf_full || buf_load) ? StLaunch : StFetch;
`else
              state_q   <= StFetch;
              req_q     <= 1'b1;
              req_idx_q <= idx_q + IdxOne;
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    B_ld  = accept;
    B_in  = accept ? vec_data : '0;
    A_ld  = fetch_go || launch;
    start = fetch_go || launch;
    A_in  = '0;
    if (fetch_go) A_in = row_data;
    else if (launch) A_in = launch_row;
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign row_req   = req_q;
  assign row_idx   = req_idx_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign res_last  = res_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vvm_seq.sv
// Directed bench for vvm_seq with a behavioural vvm engine and a row memory of adjustable latency.
module tb_vvm_seq;

  localparam int unsigned L  = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned Q  = 8;
  localparam int unsigned DQ = 18;
  localparam int unsigned M  = 4;
  localparam int unsigned RW = $clog2(M + 1);
  localparam int unsigned IW = $clog2(M);
  localparam int unsigned WL = stmm_pkg::calc_wl(L, W);
  localparam logic [L*Q-1:0] Vec = 64'h0202_0202_0202_0202;
`ifdef VVM_SEQ_PREFETCH_EN
  localparam int Ivl = WL + 3;
`else
  localparam int Ivl = 1 + WL + 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid, cmd_ready;
  logic [RW-1:0]        cmd_rows;
  logic [L*Q-1:0]       vec_data;
  logic                 row_req;
  logic [IW-1:0]        row_idx;
  logic                 row_valid;
  logic [L*Q-1:0]       row_data;
  logic [L*Q-1:0]       A_in, B_in;
  logic                 A_ld, B_ld, start;
  logic                 vvm_rdy;
  logic signed [DQ-1:0] vvm_C;
  logic                 res_valid, res_ready;
  logic signed [DQ-1:0] res_data;
  logic [IW-1:0]        res_idx;
  logic                 res_last, busy, done;

  vvm_seq #(.L(L), .W(W), .Q(Q), .DQ(DQ), .M(M)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .vec_data(vec_data), .row_req(row_req), .row_idx(row_idx), .row_valid(row_valid),
    .row_data(row_data), .A_in(A_in), .B_in(B_in), .A_ld(A_ld), .B_ld(B_ld), .start(start),
    .vvm_rdy(vvm_rdy), .vvm_C(vvm_C), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, acc_cyc = 0, row_lat = 1;
  int n_start = 0, n_done = 0, n_req = 0, n_start_norv = 0, n_bad_start = 0, n_unstable = 0;
  int done_cyc = 0;
  int q_data[$], q_idx[$], q_last[$], q_hs[$], q_rise[$], q_reqs[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [L*Q-1:0] make_row(input int idx);
    logic [L*Q-1:0] r;
    for (int i = 0; i < L; i++) r[i*Q +: Q] = Q'(idx + 1);
    return r;
  endfunction

  function automatic longint dot(input logic [L*Q-1:0] a, input logic [L*Q-1:0] b);
    longint s = 0;
    for (int i = 0; i < L; i++)
      s += longint'($signed(a[i*Q +: Q])) * longint'($signed(b[i*Q +: Q]));
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural vvm: operands captured on *_ld, rdy low for WL cycles after start.
  initial begin
    logic [L*Q-1:0] va, vb, s_ain, s_bin;
    logic s_rst, s_ald, s_bld, s_start;
    longint pend;
    int cnt;
    va = '0; vb = '0; pend = 0; cnt = 0;
    vvm_rdy = 1'b1;
    vvm_C = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_ald = A_ld; s_bld = B_ld; s_start = start; s_ain = A_in; s_bin = B_in;
      @(posedge clk);
      #1;
      if (s_rst) begin
        vvm_rdy = 1'b1; vvm_C = '0; cnt = 0;
      end else begin
        if (s_bld) vb = s_bin;
        if (s_ald) va = s_ain;
        if (s_start) begin
          pend = dot(va, vb); vvm_rdy = 1'b0; cnt = WL;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            vvm_rdy = 1'b1; vvm_C = DQ'(pend);
          end
        end
      end
    end
  end

  // Row memory: answers a request row_lat cycles after it is first seen.
  initial begin
    row_valid = 1'b0;
    row_data = '0;
    @(posedge clk);
    #1;
    forever begin
      if (row_req && !rst) begin
        for (int k = 0; k < row_lat; k++) begin
          @(posedge clk);
          #1;
        end
        if (row_req) begin
          row_valid = 1'b1;
          row_data = make_row(int'(row_idx));
          @(posedge clk);
          #1;
          row_valid = 1'b0;
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  // Observation at the falling edge, away from DUT updates.
  initial begin
    logic prev_valid = 1'b0, prev_req = 1'b0, prev_hit = 1'b0, hold = 1'b0;
    logic signed [DQ-1:0] h_data = '0;
    logic [IW-1:0] h_idx = '0;
    logic h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        q_data.push_back(int'(res_data)); q_idx.push_back(int'(res_idx));
        q_last.push_back(int'(res_last)); q_hs.push_back(cyc);
      end
      if (res_valid && !prev_valid) q_rise.push_back(cyc);
      if (row_req && (!prev_req || prev_hit)) begin
        q_reqs.push_back(cyc);
        n_req++;
      end
      if (done) begin
        n_done++; done_cyc = cyc;
      end
      if (start) begin
        n_start++;
        if (!vvm_rdy) n_bad_start++;
        if (!row_valid) n_start_norv++;
      end
      if (hold && (!res_valid || res_data !== h_data || res_idx !== h_idx || res_last !== h_last))
        n_unstable++;
      hold = res_valid && !res_ready;
      h_data = res_data; h_idx = res_idx; h_last = res_last;
      prev_valid = res_valid; prev_req = row_req; prev_hit = row_req && row_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    q_data.delete(); q_idx.delete(); q_last.delete(); q_hs.delete();
    q_rise.delete(); q_reqs.delete();
    n_start = 0; n_done = 0; n_req = 0; n_start_norv = 0;
  endtask

  task automatic issue_cmd(input int rows);
    cmd_valid = 1'b1;
    cmd_rows = RW'(rows);
    @(negedge clk);
    check("accept_ready", cmd_ready, 1);
    check("accept_bld", B_ld, 1);
    check("accept_bin", B_in, Vec);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    step(1);
  endtask

  task automatic check_results(input string tag, input int n);
    check({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < q_data.size()) begin
        check({tag, "_data"}, q_data[i], 16 * (i + 1));
        check({tag, "_idx"}, q_idx[i], i);
        check({tag, "_last"}, q_last[i], (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rows = '0; vec_data = Vec; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_row_req", row_req, 0);
    check("rst_done", done, 0);
    check("rst_start", start, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);

    // Three rows, no backpressure
    clear();
    issue_cmd(3);
    wait_done(100);
    step(3);
    check_results("t1", 3);
    check("t1_done_pulses", n_done, 1);
    if (q_hs.size() == 3) check("t1_done_cyc", done_cyc, q_hs[2] + 1);
    if (q_rise.size() > 0) check("t1_first_lat", q_rise[0] - acc_cyc, WL + 4);
    if (q_reqs.size() > 0) check("t1_req_from1", q_reqs[0] - acc_cyc, 1);

    // Empty command
    clear();
    issue_cmd(0);
    @(negedge clk);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    step(1);
    @(negedge clk);
    check("t2_done_drop", done, 0);
    step(3);
    check("t2_no_req", n_req, 0);
    check("t2_no_res", q_data.size(), 0);
    check("t2_done_pulses", n_done, 1);

    // Result backpressure on the first row
    clear();
    res_ready = 1'b0;
    issue_cmd(2);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("t3_valid", seen, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t3_hold", res_data, 16);
    end
    check("t3_no_start", n_start, 1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_done(100);
    step(2);
    check_results("t3", 2);
    check("t3_unstable", n_unstable, 0);

    // Slow row memory
    clear();
    row_lat = 7;
    issue_cmd(2);
    wait_done(200);
    step(2);
    check_results("t4", 2);
    check("t4_starts", n_start, 2);
    check("t4_start_on_rv", n_start_norv, 0);
    row_lat = 1;

    // Reset during the second run
    clear();
    issue_cmd(4);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (n_start >= 2) seen = 1'b1;
    end
    check("t5_second_start", seen, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_res_valid", res_valid, 0);
    check("t5_row_req", row_req, 0);
    check("t5_res_before", q_data.size(), 1);
    step(1);
    clear();
    issue_cmd(1);
    wait_done(100);
    step(2);
    check_results("t5", 1);

    // Four rows: steady-state interval and request overlap
    clear();
    issue_cmd(4);
    wait_done(200);
    step(2);
    check_results("t6", 4);
    check("t6_rises", q_rise.size(), 4);
    for (int i = 0; i < 3; i++)
      if (i + 1 < q_rise.size()) check("t6_interval", q_rise[i+1] - q_rise[i], Ivl);
    if (q_reqs.size() > 1 && q_rise.size() > 0) begin
`ifdef VVM_SEQ_PREFETCH_EN
      check("t6_req_in_run", q_reqs[1] - acc_cyc, 3);
`else
      check("t6_req_serial", q_reqs[1] - q_rise[0], 1);
`endif
    end

    check("start_while_busy_vvm", n_bad_start, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
